axi_rd_rr_scheduler: RTL and testbench



---
 rtl/axi_rd_rr_if.sv | 26 ++
 rtl/axi_rd_rr_scheduler.sv | 114 +++++++++++
 tb/tb_axi_rd_rr_scheduler.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_rr_if.sv
// Handshake bundle between the AR request queues, the downstream AR channel
// and the read-address scheduler.
interface axi_rd_rr_if #(
  parameter int CNTW = 4
) ();
  logic [3:0]        req_vld;
  logic [3:0]        req_rdy;
  logic              grant_vld;
  logic [1:0]        grant_sel;
  logic              arready;
  logic [3:0]        done_vld;
  logic              quiesce;
  logic              idle;
  logic [4*CNTW-1:0] out_cnt;
  logic [3:0]        err;

  modport slave (
    input  req_vld, arready, done_vld, quiesce,
    output req_rdy, grant_vld, grant_sel, idle, out_cnt, err
  );

  modport master (
    output req_vld, arready, done_vld, quiesce,
    input  req_rdy, grant_vld, grant_sel, idle, out_cnt, err
  );
endinterface

// File: rtl/axi_rd_rr_scheduler.sv
// Round-robin AR scheduler for a 4-to-1 read merger: holds each offer until
// arready, tracks per-port outstanding bursts, and reports idle for quiesce.
//
//   state   | meaning
//   S_IDLE  | no offer on the downstream AR channel
//   S_OFFER | grant_vld=1, grant_sel held until arready
module axi_rd_rr_scheduler #(
  parameter int MAXOUT = 8,
  parameter int CNTW   = 4
) (
  input  logic        clk,
  input  logic        rst,
  axi_rd_rr_if.slave  bus
);
  typedef enum logic {S_IDLE, S_OFFER} state_e;

  localparam logic [CNTW-1:0] MAX_C = CNTW'(MAXOUT);

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q [4];
  logic [CNTW-1:0] cnt_d [4];
  logic [3:0]      err_q, err_d;

  logic            accept;
  logic [3:0]      inc;
  logic [3:0]      elig;
  logic            found;
  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            all_zero;

  always_comb begin
    accept = (state_q == S_OFFER) && bus.arready;
    inc    = accept ? (4'b0001 << sel_q) : 4'b0000;
    err_d  = err_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !bus.done_vld[i]) begin
        cnt_d[i] = cnt_q[i] + CNTW'(1);
      end else if (bus.done_vld[i] && !inc[i]) begin
        if (cnt_q[i] == '0) err_d[i] = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNTW'(1);
      end
    end
    ptr_d = accept ? (sel_q + 2'd1) : ptr_q;

    // After an accept the just-granted port is masked and fresh counts apply.
    for (int i = 0; i < 4; i++) begin
      elig[i] = bus.req_vld[i] && !bus.quiesce && !inc[i] &&
                ((accept ? cnt_d[i] : cnt_q[i]) < MAX_C);
    end

    found  = 1'b0;
    winner = ptr_d;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_d + 2'(k);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end

    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_OFFER;
          sel_d   = winner;
        end
      end
      S_OFFER: begin
        if (accept) begin
          if (found) sel_d   = winner;
          else       state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    all_zero    = 1'b1;
    bus.out_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      bus.out_cnt[i*CNTW +: CNTW] = cnt_q[i];
      if (cnt_q[i] != '0) all_zero = 1'b0;
    end
  end

  assign bus.req_rdy   = inc;
  assign bus.grant_vld = (state_q == S_OFFER);
  assign bus.grant_sel = sel_q;
  assign bus.idle      = (state_q == S_IDLE) && all_zero;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_axi_rd_rr_scheduler.sv
// Directed bench for axi_rd_rr_scheduler: a per-cycle reference model checked
// on every falling edge, plus literal expectations along each scenario.
module tb_axi_rd_rr_scheduler;
  localparam int MAXOUT = 8;
  localparam int CNTW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  axi_rd_rr_if #(.CNTW(CNTW)) bus ();

  axi_rd_rr_scheduler #(.MAXOUT(MAXOUT), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be after the next rising edge.
  bit       m_valid = 0;
  bit       m_offer;
  int       m_sel, m_ptr;
  int       m_cnt [4];
  bit [3:0] m_err;

  task automatic model_step();
    int nc [4];
    bit acc, inc, dec, found, ok;
    int start, nsel, j;
    if (rst) begin
      m_offer = 0; m_sel = 0; m_ptr = 0; m_err = '0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_valid = 1;
      return;
    end
    acc = m_offer && bus.arready;
    for (int i = 0; i < 4; i++) begin
      nc[i] = m_cnt[i];
      inc = acc && (m_sel == i);
      dec = bus.done_vld[i];
      if (inc && !dec) nc[i]++;
      else if (dec && !inc) begin
        if (m_cnt[i] == 0) m_err[i] = 1'b1;
        else nc[i]--;
      end
    end
    if (!m_offer || acc) begin
      start = acc ? (m_sel + 1) % 4 : m_ptr;
      found = 0;
      nsel  = 0;
      for (int k = 0; k < 4; k++) begin
        j  = (start + k) % 4;
        ok = bus.req_vld[j] && !bus.quiesce && !(acc && j == m_sel) &&
             ((acc ? nc[j] : m_cnt[j]) < MAXOUT);
        if (!found && ok) begin
          found = 1;
          nsel  = j;
        end
      end
      if (acc) m_ptr = start;
      m_offer = found;
      if (found) m_sel = nsel;
    end
    for (int i = 0; i < 4; i++) m_cnt[i] = nc[i];
  endtask

  always @(negedge clk) begin
    logic [31:0] pk;
    bit          idle_exp;
    if (m_valid) begin
      pk = '0;
      idle_exp = !m_offer;
      for (int i = 0; i < 4; i++) begin
        pk = pk | (32'(m_cnt[i]) << (i * CNTW));
        if (m_cnt[i] != 0) idle_exp = 0;
      end
      check("mdl_grant_vld", 32'(bus.grant_vld), 32'(m_offer));
      if (m_offer) check("mdl_grant_sel", 32'(bus.grant_sel), 32'(m_sel));
      check("mdl_req_rdy", 32'(bus.req_rdy), (m_offer && bus.arready) ? (32'd1 << m_sel) : 32'd0);
      check("mdl_out_cnt", 32'(bus.out_cnt), pk);
      check("mdl_err", 32'(bus.err), 32'(m_err));
      check("mdl_idle", 32'(bus.idle), 32'(idle_exp));
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_acc;

  initial begin
    bus.req_vld  = 4'hF;
    bus.arready  = 1'b0;
    bus.done_vld = 4'h0;
    bus.quiesce  = 1'b0;
    rst          = 1'b1;

    // Reset while every port requests
    tick(); tick(); #1;
    check("rst_grant_vld", 32'(bus.grant_vld), 0);
    check("rst_out_cnt", 32'(bus.out_cnt), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_idle", 32'(bus.idle), 1);
    rst = 1'b0;
    tick(); #1;
    check("first_grant_vld", 32'(bus.grant_vld), 1);
    check("first_grant_sel", 32'(bus.grant_sel), 0);

    // Round robin, back-to-back
    bus.arready = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      check("rr_sel", 32'(bus.grant_sel), 32'(i % 4));
      check("rr_vld", 32'(bus.grant_vld), 1);
      check("rr_rdy", 32'(bus.req_rdy), 32'd1 << (i % 4));
      tick(); #1;
    end
    bus.req_vld = 4'h0;
    tick(); #1;
    check("rr_cnt", 32'(bus.out_cnt), 32'h2223);
    check("rr_vld_off", 32'(bus.grant_vld), 0);
    bus.arready  = 1'b0;
    bus.done_vld = 4'hF;
    tick(); tick();
    bus.done_vld = 4'b0001;
    tick();
    bus.done_vld = 4'h0; #1;
    check("rr_drain_cnt", 32'(bus.out_cnt), 0);
    check("rr_drain_idle", 32'(bus.idle), 1);

    // Stability of a stalled offer (ptr=1)
    bus.req_vld = 4'b1100;
    tick(); #1;
    check("stab_sel0", 32'(bus.grant_sel), 2);
    bus.req_vld = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check("stab_sel", 32'(bus.grant_sel), 2);
      check("stab_vld", 32'(bus.grant_vld), 1);
    end
    bus.arready = 1'b1; #1;
    check("stab_rdy", 32'(bus.req_rdy), 32'b0100);
    tick(); #1;
    check("stab_next3", 32'(bus.grant_sel), 3);
    tick(); #1;
    check("stab_next0", 32'(bus.grant_sel), 0);
    bus.req_vld = 4'h0;
    tick(); #1;
    check("stab_vld_off", 32'(bus.grant_vld), 0);
    check("stab_cnt", 32'(bus.out_cnt), 32'h1101);
    bus.arready  = 1'b0;
    bus.done_vld = 4'b1101;
    tick();
    bus.done_vld = 4'h0; #1;
    check("stab_drain", 32'(bus.out_cnt), 0);

    // Credit limit on port 1 (ptr=1)
    bus.req_vld = 4'b0010;
    bus.arready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 30; i++) begin
      tick(); #1;
      if (bus.req_rdy[1]) n_acc++;
    end
    check("cred_accepts", 32'(n_acc), 8);
    check("cred_vld", 32'(bus.grant_vld), 0);
    check("cred_cnt8", 32'(bus.out_cnt), 32'h0080);
    bus.done_vld = 4'b0010;
    tick();
    bus.done_vld = 4'h0; #1;
    check("cred_cnt7", 32'(bus.out_cnt), 32'h0070);
    check("cred_vld_wait", 32'(bus.grant_vld), 0);
    tick(); #1;
    check("cred_regrant", 32'(bus.grant_vld), 1);
    check("cred_regrant_sel", 32'(bus.grant_sel), 1);
    check("cred_regrant_rdy", 32'(bus.req_rdy), 32'b0010);
    tick(); #1;
    check("cred_cnt8b", 32'(bus.out_cnt), 32'h0080);
    check("cred_vld_off", 32'(bus.grant_vld), 0);
    bus.req_vld  = 4'h0;
    bus.arready  = 1'b0;
    bus.done_vld = 4'b0010;
    repeat (8) tick();
    bus.done_vld = 4'h0; #1;
    check("cred_drain", 32'(bus.out_cnt), 0);
    check("cred_idle", 32'(bus.idle), 1);

    // Accept and done on port 3 together, then underflow on port 0 (ptr=2)
    bus.req_vld = 4'b1000;
    tick(); #1;
    check("sim_sel3", 32'(bus.grant_sel), 3);
    bus.arready = 1'b1;
    bus.req_vld = 4'h0;
    tick(); #1;
    check("sim_cnt1", 32'(bus.out_cnt), 32'h1000);
    bus.arready = 1'b0;
    bus.req_vld = 4'b1000;
    tick(); #1;
    check("sim_sel3b", 32'(bus.grant_sel), 3);
    bus.arready  = 1'b1;
    bus.req_vld  = 4'h0;
    bus.done_vld = 4'b1000; #1;
    check("sim_rdy", 32'(bus.req_rdy), 32'b1000);
    tick();
    bus.done_vld = 4'h0;
    bus.arready  = 1'b0; #1;
    check("sim_cnt_same", 32'(bus.out_cnt), 32'h1000);
    bus.done_vld = 4'b0001;
    tick();
    bus.done_vld = 4'h0; #1;
    check("udf_err", 32'(bus.err), 32'b0001);
    check("udf_cnt", 32'(bus.out_cnt), 32'h1000);
    tick(); #1;
    check("udf_err_held", 32'(bus.err), 32'b0001);
    bus.done_vld = 4'b1000;
    tick();
    bus.done_vld = 4'h0; #1;
    check("udf_drain", 32'(bus.out_cnt), 0);
    check("udf_err_only0", 32'(bus.err), 32'b0001);

    // Quiesce mid-offer (ptr=0)
    bus.req_vld = 4'b0110;
    tick(); #1;
    check("q_sel1", 32'(bus.grant_sel), 1);
    bus.quiesce = 1'b1;
    tick(); #1;
    check("q_hold_vld", 32'(bus.grant_vld), 1);
    check("q_hold_sel", 32'(bus.grant_sel), 1);
    bus.arready = 1'b1; #1;
    check("q_rdy", 32'(bus.req_rdy), 32'b0010);
    tick();
    bus.arready = 1'b0; #1;
    check("q_vld_off", 32'(bus.grant_vld), 0);
    check("q_not_idle", 32'(bus.idle), 0);
    tick(); #1;
    check("q_still_off", 32'(bus.grant_vld), 0);
    bus.done_vld = 4'b0010;
    tick();
    bus.done_vld = 4'h0; #1;
    check("q_idle", 32'(bus.idle), 1);
    bus.quiesce = 1'b0;
    tick(); #1;
    check("q_resume_vld", 32'(bus.grant_vld), 1);
    check("q_resume_sel", 32'(bus.grant_sel), 2);

    // Reset during a stalled offer
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("rst_mid_vld", 32'(bus.grant_vld), 0);
    check("rst_mid_err", 32'(bus.err), 0);
    check("rst_mid_idle", 32'(bus.idle), 1);
    tick(); #1;
    check("rst_mid_regrant", 32'(bus.grant_sel), 1);
    bus.req_vld = 4'h0;
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
